// File: rtl/pipeline_interlock_unit.sv
// pipeline_interlock_unit: stall/flush controller for the 5-stage SimpleRISC pipeline.
//   clk            pipeline clock
//   rst            asynchronous active-low reset
//   instruction_of / valid_of   instruction in OF and its valid flag
//   instruction_e  / valid_e    instruction in EX and its valid flag
//   branch_taken_e EX branch resolved taken this cycle
//   stall_if/of/ex hold PC+IF-OF / OF-EX / EX-M input
//   bubble_ex/m    load nop into OF-EX / EX-M
//   flush_if/of    squash IF-OF / OF-EX
//   mdu_busy       multi-cycle op still occupying EX
//   stall_cycles   saturating count of cycles with stall_if=1
module pipeline_interlock_unit #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction_of,
    input  logic             valid_of,
    input  logic [31:0]      instruction_e,
    input  logic             valid_e,
    input  logic             branch_taken_e,
    output logic             stall_if,
    output logic             stall_of,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             bubble_m,
    output logic             flush_if,
    output logic             flush_of,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_MOD = 5'b00100;
    localparam logic [4:0] OP_NOT = 5'b01000;
    localparam logic [4:0] OP_MOV = 5'b01001;
    localparam logic [4:0] OP_LD  = 5'b01110;
    localparam logic [4:0] OP_ST  = 5'b01111;
    localparam logic [4:0] OP_RET = 5'b10100;
    localparam logic [4:0] OP_ALU_MAX = 5'b01100;

    typedef enum logic {IDLE, MDU_BUSY} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [4:0] op_of, op_e;
    logic [3:0] rs1_of, rs2_of, rd_e;
    logic       alu_of, rs1_use, rs2_use, ret_use;
    logic       flush, load_use, mdu_start, busy_stall, stall_any;
    int         mdu_lat;

    always_comb begin
        op_of      = instruction_of[31:27];
        rs1_of     = instruction_of[21:18];
        rs2_of     = instruction_of[17:14];
        op_e       = instruction_e[31:27];
        rd_e       = instruction_e[25:22];
        alu_of     = op_of <= OP_ALU_MAX;
        // st data (rd field) is deliberately absent: RW->M forwarding covers it
        rs1_use    = (alu_of && op_of != OP_NOT && op_of != OP_MOV) || op_of == OP_LD || op_of == OP_ST;
        rs2_use    = alu_of && !instruction_of[26];
        ret_use    = op_of == OP_RET;
        mdu_lat    = op_e == OP_MUL ? MUL_LAT : (op_e == OP_DIV || op_e == OP_MOD) ? DIV_LAT : 1;
        flush      = valid_e && branch_taken_e;
        mdu_start  = state_q == IDLE && valid_e && mdu_lat > 1 && !flush;
        busy_stall = state_q == MDU_BUSY && cnt_q != 4'd0 && !flush;
        load_use   = state_q == IDLE && !flush && !mdu_start && valid_e && valid_of && op_e == OP_LD &&
                     ((rs1_use && rs1_of == rd_e) || (rs2_use && rs2_of == rd_e) || (ret_use && rd_e == 4'd15));
        stall_any  = mdu_start || busy_stall;
        stall_if   = rst && (stall_any || load_use);
        stall_of   = stall_if;
        stall_ex   = rst && stall_any;
        bubble_m   = stall_ex;
        bubble_ex  = rst && load_use;
        flush_if   = rst && flush;
        flush_of   = flush_if;
        mdu_busy   = rst && state_q == MDU_BUSY && cnt_q != 4'd0;
        // cnt==0 in MDU_BUSY is the release cycle; the same instruction must not restart
        state_d    = state_q == MDU_BUSY ? (cnt_q != 4'd0 ? MDU_BUSY : IDLE) : (mdu_start ? MDU_BUSY : IDLE);
        cnt_d      = state_q == MDU_BUSY ? (cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd0) :
                     (mdu_start ? 4'(mdu_lat - 2) : 4'd0);
        stall_cycles_d = (stall_if && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1 : stall_cycles_q;
        stall_cycles   = stall_cycles_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
endmodule

// File: tb/tb_pipeline_interlock_unit.sv
// tb_pipeline_interlock_unit: directed self-checking bench for pipeline_interlock_unit.
module tb_pipeline_interlock_unit;
    localparam logic [4:0] ADD = 5'b00000, DIV = 5'b00011, MUL = 5'b00010, NOT = 5'b01000;
    localparam logic [4:0] NOP = 5'b01101, LD = 5'b01110, ST = 5'b01111, RET = 5'b10100, BEQ = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction_of = '0, instruction_e = '0;
    logic        valid_of = 1'b0, valid_e = 1'b0, branch_taken_e = 1'b0;
    logic        stall_if, stall_of, stall_ex, bubble_ex, bubble_m, flush_if, flush_of, mdu_busy;
    logic [15:0] stall_cycles;
    logic [7:0]  outs, exp;
    int          n_checks = 0, n_fail = 0;

    assign outs = {stall_if, stall_of, stall_ex, bubble_ex, bubble_m, flush_if, flush_of, mdu_busy};

    pipeline_interlock_unit #(.MUL_LAT(3), .DIV_LAT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .instruction_of(instruction_of), .valid_of(valid_of),
        .instruction_e(instruction_e), .valid_e(valid_e), .branch_taken_e(branch_taken_e),
        .stall_if(stall_if), .stall_of(stall_of), .stall_ex(stall_ex),
        .bubble_ex(bubble_ex), .bubble_m(bubble_m),
        .flush_if(flush_if), .flush_of(flush_of),
        .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic imm,
                                        input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, imm, rd, rs1, rs2, 14'd0};
    endfunction

    task automatic drive(input logic [31:0] ie, input logic ve, input logic [31:0] io, input logic vo, input logic bt);
        instruction_e = ie; valid_e = ve; instruction_of = io; valid_of = vo; branch_taken_e = bt;
    endtask

    task automatic step_check(input logic [7:0] e, input string name);
        #1;
        n_checks++;
        if (outs !== e) begin
            n_fail++;
            $display("FAIL %s: outs=%b expected %b", name, outs, e);
        end
    endtask

    task automatic cnt_check(input logic [15:0] e, input string name);
        n_checks++;
        if (stall_cycles !== e) begin
            n_fail++;
            $display("FAIL %s: stall_cycles=%h expected %h", name, stall_cycles, e);
        end
    endtask

    task automatic bubble_cycle();
        @(negedge clk);
        drive(enc(NOP, 0, 0, 0, 0), 1, enc(ADD, 0, 1, 2, 2), 1, 0);
    endtask

    task automatic test_reset();
        drive(enc(LD, 1, 3, 1, 0), 1, enc(ADD, 0, 5, 3, 4), 1, 0);
        repeat (2) @(negedge clk);
        step_check(8'h00, "reset_outs");
        cnt_check(16'h0000, "reset_cnt");
        rst = 1'b1;
        drive(enc(NOP, 0, 0, 0, 0), 1, enc(NOP, 0, 0, 0, 0), 1, 0);
    endtask

    task automatic test_load_use();
        @(negedge clk);
        drive(enc(LD, 1, 3, 1, 0), 1, enc(ADD, 0, 5, 3, 4), 1, 0);
        step_check(8'hD0, "load_use_stall");
        @(negedge clk);
        drive(enc(NOP, 0, 0, 0, 0), 1, enc(ADD, 0, 5, 3, 4), 1, 0);
        step_check(8'h00, "load_use_clear");
        cnt_check(16'd1, "load_use_cnt");
    endtask

    task automatic test_store();
        @(negedge clk);
        drive(enc(LD, 1, 3, 1, 0), 1, enc(ST, 1, 3, 6, 0), 1, 0);
        step_check(8'h00, "st_data_no_stall");
        @(negedge clk);
        drive(enc(LD, 1, 3, 1, 0), 1, enc(ST, 1, 7, 3, 0), 1, 0);
        step_check(8'hD0, "st_addr_stall");
        bubble_cycle();
        step_check(8'h00, "st_addr_clear");
        cnt_check(16'd2, "st_cnt");
    endtask

    task automatic test_sources();
        @(negedge clk);
        drive(enc(LD, 1, 3, 1, 0), 1, enc(ADD, 1, 5, 6, 3), 1, 0);
        step_check(8'h00, "imm_rs2_ignored");
        @(negedge clk);
        drive(enc(LD, 1, 3, 1, 0), 1, enc(ADD, 0, 5, 3, 4), 0, 0);
        step_check(8'h00, "valid_of_low");
        @(negedge clk);
        drive(enc(LD, 1, 3, 1, 0), 0, enc(ADD, 0, 5, 3, 4), 1, 0);
        step_check(8'h00, "valid_e_low");
        @(negedge clk);
        drive(enc(LD, 1, 15, 1, 0), 1, enc(RET, 0, 0, 0, 0), 1, 0);
        step_check(8'hD0, "ret_r15_stall");
        bubble_cycle();
        drive(enc(LD, 1, 3, 1, 0), 1, enc(NOT, 0, 5, 3, 4), 1, 0);
        step_check(8'h00, "not_rs1_ignored");
        @(negedge clk);
        drive(enc(LD, 1, 3, 1, 0), 1, enc(NOT, 0, 5, 4, 3), 1, 0);
        step_check(8'hD0, "not_rs2_stall");
        bubble_cycle();
        cnt_check(16'd4, "sources_cnt");
    endtask

    task automatic test_mdu();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) drive(enc(DIV, 0, 1, 2, 3), 1, enc(ADD, 0, 5, 6, 7), 1, 0);
            step_check(i == 1 ? 8'hE8 : i < 8 ? 8'hE9 : 8'h00, $sformatf("div_cycle%0d", i));
        end
        drive(enc(NOP, 0, 0, 0, 0), 1, enc(ADD, 0, 5, 6, 7), 1, 0);
        @(negedge clk);
        step_check(8'h00, "div_after");
        cnt_check(16'd11, "div_cnt");
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) drive(enc(MUL, 0, 1, 2, 3), 1, enc(ADD, 0, 5, 6, 7), 1, 0);
            step_check(i == 1 ? 8'hE8 : i == 2 ? 8'hE9 : 8'h00, $sformatf("mul_cycle%0d", i));
        end
        drive(enc(NOP, 0, 0, 0, 0), 1, enc(ADD, 0, 5, 6, 7), 1, 0);
        @(negedge clk);
        cnt_check(16'd13, "mul_cnt");
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive(enc(BEQ, 0, 0, 0, 0), 1, enc(ADD, 0, 5, 3, 4), 1, 1);
        step_check(8'h06, "flush_branch");
        @(negedge clk);
        drive(enc(LD, 1, 3, 1, 0), 1, enc(ADD, 0, 5, 3, 4), 1, 1);
        step_check(8'h06, "flush_over_load_use");
        @(negedge clk);
        drive(enc(DIV, 0, 1, 2, 3), 1, enc(ADD, 0, 5, 6, 7), 1, 1);
        step_check(8'h06, "flush_over_mdu");
        @(negedge clk);
        drive(enc(NOP, 0, 0, 0, 0), 1, enc(ADD, 0, 5, 6, 7), 1, 0);
        step_check(8'h00, "flush_no_mdu_start");
        cnt_check(16'd13, "flush_cnt");
    endtask

    task automatic test_reset_mid_div();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) drive(enc(DIV, 0, 1, 2, 3), 1, enc(ADD, 0, 5, 6, 7), 1, 0);
            step_check(i == 1 ? 8'hE8 : 8'hE9, $sformatf("rdiv_cycle%0d", i));
        end
        @(negedge clk);
        rst = 1'b0;
        step_check(8'h00, "rdiv_reset_outs");
        cnt_check(16'd0, "rdiv_reset_cnt");
        @(negedge clk);
        rst = 1'b1;
        drive(enc(ADD, 0, 1, 2, 3), 1, enc(ADD, 0, 5, 6, 7), 1, 0);
        step_check(8'h00, "rdiv_fresh_add");
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) drive(enc(DIV, 0, 1, 2, 3), 1, enc(ADD, 0, 5, 6, 7), 1, 0);
            step_check(i == 1 ? 8'hE8 : i < 8 ? 8'hE9 : 8'h00, $sformatf("rdiv_fresh%0d", i));
        end
        drive(enc(NOP, 0, 0, 0, 0), 1, enc(ADD, 0, 5, 6, 7), 1, 0);
        @(negedge clk);
        cnt_check(16'd7, "rdiv_cnt");
    endtask

    task automatic test_saturation();
        @(negedge clk);
        drive(enc(LD, 1, 3, 1, 0), 1, enc(ADD, 0, 5, 3, 4), 1, 0);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        cnt_check(16'hFFFF, "sat_reach");
        step_check(8'hD0, "sat_still_stalling");
        repeat (3) @(posedge clk);
        @(negedge clk);
        cnt_check(16'hFFFF, "sat_hold");
        drive(enc(NOP, 0, 0, 0, 0), 1, enc(NOP, 0, 0, 0, 0), 1, 0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_store();
        test_sources();
        test_mdu();
        test_flush();
        test_reset_mid_div();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_interlock_unit.md
Name: pipeline_interlock_unit

Overview:
Stall/flush controller for the 5-stage SimpleRISC pipeline (IF, OF, EX, M, RW). It works alongside the forwarding logic and covers the hazards that bypassing cannot resolve:
- load-use dependences,
- multi-cycle mul/div/mod occupancy of EX,
- taken-branch wrong-path squash.

It drives stage-hold and bubble/flush controls into the pipeline registers and keeps a stall-cycle performance counter.

Parameters:
MUL_LAT, 3, EX cycles for mul (1 = single-cycle, no stall)
DIV_LAT, 8, EX cycles for div and mod
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  pipeline clock
rst  in  1  reset, asynchronous, active-low
instruction_of  in  32  instruction in OF stage
valid_of  in  1  OF holds a real instruction
instruction_e  in  32  instruction in EX stage
valid_e  in  1  EX holds a real instruction
branch_taken_e  in  1  EX branch resolved taken this cycle
stall_if  out  1  hold PC / IF-OF register
stall_of  out  1  hold OF-EX register
stall_ex  out  1  hold EX-M register input instruction (EX busy)
bubble_ex  out  1  load nop into OF-EX register
bubble_m  out  1  load nop into EX-M register
flush_if  out  1  squash IF-OF register
flush_of  out  1  squash OF-EX register
mdu_busy  out  1  FSM in MDU_BUSY
stall_cycles  out  CNT_W  saturating count of cycles with stall_if=1

Behaviour:
- Instruction field map:
  - opcode [31:27], imm bit [26], rd [25:22], rs1 [21:18], rs2 [17:14].
  - Opcodes: mul 00010, div 00011, mod 00100, cmp 00101, not 01000, mov 01001, nop 01101, ld 01110, st 01111, ret 10100; branches/call 10000-10011.
- OF source usage:
  - rs1 read by all ALU ops except not/mov/nop, and by cmp/ld/st.
  - rs2 read when imm=0 by ALU ops, cmp, not and mov.
  - ret reads r15.
  - st data register (rd field) is NOT a stall source; it is covered by RW->M forwarding.
- load_use = valid_e & valid_of & opcode_e==ld & (rd_e matches any register OF reads per above).
- FSM states: IDLE, MDU_BUSY. 4-bit down-counter cnt.
- Priority, highest first: flush > MDU occupancy > load-use.
- Flush:
  - Condition: valid_e & branch_taken_e.
  - flush_if=flush_of=1 the same cycle (combinational).
  - All stall/bubble outputs 0 that cycle.
- MDU occupancy, entered from IDLE:
  - Condition: valid_e and opcode_e is mul (L=MUL_LAT) or div/mod (L=DIV_LAT), with L>1.
  - That cycle: stall_if=stall_of=stall_ex=bubble_m=1.
  - Registered: cnt<=L-2, state<=MDU_BUSY.
- MDU_BUSY:
  - cnt!=0: same four outputs=1, cnt<=cnt-1.
  - cnt==0: outputs 0, instruction advances, state<=IDLE.
  - Total stall cycles = L-1. No retrigger on the same instruction.
- Load-use, in IDLE with no flush and no MDU start:
  - stall_if=stall_of=1, bubble_ex=1 for exactly one cycle.
  - The next cycle EX holds the bubble, so the condition clears naturally.
- All control outputs are combinational from state plus stage inputs. mdu_busy is combinational from state.
- stall_cycles increments on each clk edge where stall_if=1, and saturates at all-ones.
- L==1 opcodes never stall.
- valid_e=0 or valid_of=0 suppresses the corresponding detection.
- Reset (async, rst=0), including mid-MDU_BUSY:
  - state=IDLE, cnt=0, stall_cycles=0.
  - All outputs 0 while rst=0.
  - Operation resumes on the first edge after release.

Test Plan:
1. EX ld r3 (valid), OF add r5,r3,r4 -> one cycle with stall_if=stall_of=bubble_ex=1; following cycle all 0; stall_cycles=1.
2. EX ld r3, OF st r3,[r6] -> no stall (data forwarded); EX ld r3, OF st r7,[r3] -> one-cycle stall.
3. EX div with DIV_LAT=8 -> stall_if/of/ex and bubble_m high 7 consecutive cycles, mdu_busy high cycles 2-7, 8th cycle all low; stall_cycles +7.
4. EX branch with branch_taken_e=1 while OF holds a load-use candidate -> flush_if=flush_of=1, bubble_ex=0, stall_if=0.
5. rst pulled low during cycle 4 of a div -> outputs 0 immediately, mdu_busy=0, stall_cycles=0; after release the next EX instruction is evaluated fresh.
6. EX ld r3 with OF add r5,r6,#3 (imm=1, rs2 field=3) -> no stall; preload stall_cycles to 16'hFFFF, force stall -> remains 16'hFFFF.
